// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin sharing of one SPI master between NUM_REQ requesters with timeout abort
module spi_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          done,
  output logic                          err,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          spi_enable,
  output logic [DATA_WIDTH-1:0]         spi_data_in,
  input  logic                          spi_cs,
  input  logic [DATA_WIDTH-1:0]         spi_data_out,
  output logic                          spi_abort,
  output logic [NUM_REQ-1:0]            ss_n
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;
  state_t                 state_q;
  logic [IW-1:0]          ptr_q, idx_q, idx_d;
  logic [CW-1:0]          cnt_q;
  logic                   seen_q, found_d;
  logic [DATA_WIDTH-1:0]  rx_q, rsp_q, din_q, tx_d;
  logic [NUM_REQ-1:0]     grant_q;
  logic                   done_q, err_q, en_q, abort_q;
  // first requesting index at or above the pointer, wrapping; scanning downward leaves the nearest one
  always_comb begin
    found_d = 1'b0;
    idx_d = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--)
      if (req[(int'(ptr_q) + j) % NUM_REQ]) begin
        found_d = 1'b1;
        idx_d = IW'((int'(ptr_q) + j) % NUM_REQ);
      end
    tx_d = req_data[idx_d*DATA_WIDTH +: DATA_WIDTH];
  end
  // transaction sequencer: arbitrate, kick the master, track cs, complete or abort
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      seen_q  <= 1'b0;
      rx_q    <= '0;
      rsp_q   <= '0;
      din_q   <= '0;
      grant_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      en_q    <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      en_q    <= 1'b0;
      abort_q <= 1'b0;
      case (state_q)
        IDLE: if (found_d) begin
          grant_q <= NUM_REQ'(1) << idx_d;
          idx_q   <= idx_d;
          din_q   <= tx_d;
          cnt_q   <= '0;
          seen_q  <= 1'b0;
          state_q <= START;
        end
        START: begin
          en_q    <= 1'b1;
          state_q <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (!spi_cs) begin
            rx_q   <= spi_data_out;
            seen_q <= 1'b1;
          end
          if (spi_cs && seen_q) begin
            done_q  <= 1'b1;
            rsp_q   <= rx_q;
            state_q <= DONE;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            abort_q <= 1'b1;
            rsp_q   <= '0;
            state_q <= DONE;
          end
        end
        DONE: begin
          grant_q <= '0;
          ptr_q   <= (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end
  assign grant       = grant_q;
  assign done        = done_q;
  assign err         = err_q;
  assign rsp_data    = rsp_q;
  assign spi_enable  = en_q;
  assign spi_data_in = din_q;
  assign spi_abort   = abort_q;
  assign ss_n        = (state_q == START || state_q == WAIT) ? (~grant_q | {NUM_REQ{spi_cs}}) : '1;
endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: directed tests with a transaction-level reference model checked every cycle
module tb_spi_arbiter;
  localparam int N = 4, W = 8, TO = 16, LEN = 4;
  logic clk = 1'b0, reset = 1'b1;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0] grant, ss_n;
  logic done, err, spi_enable, spi_abort;
  logic [W-1:0] rsp_data, spi_data_in;
  logic spi_cs = 1'b1;
  logic [W-1:0] spi_data_out = '0;
  logic [W-1:0] slave_word [N] = '{8'h3C, 8'h5A, 8'hC3, 8'h81};
  int errors = 0, checks = 0;
  bit chk_on = 1'b0, hang = 1'b0;
  always #5 clk = ~clk;
  spi_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .grant(grant), .done(done),
    .err(err), .rsp_data(rsp_data), .spi_enable(spi_enable), .spi_data_in(spi_data_in),
    .spi_cs(spi_cs), .spi_data_out(spi_data_out), .spi_abort(spi_abort), .ss_n(ss_n));
  function automatic int gidx(input logic [N-1:0] g);
    gidx = 0;
    for (int i = 0; i < N; i++) if (g[i]) gidx = i;
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // slave device: after an enable pulse, holds cs low LEN cycles ending on its word (or forever when hung)
  initial begin
    bit busy;
    int k;
    logic [W-1:0] word;
    busy = 0; k = 0; word = '0;
    forever begin
      @(posedge clk); #1;
      if (reset || spi_abort) begin
        spi_cs = 1'b1; busy = 0; spi_data_out = '0;
      end else if (spi_enable) begin
        busy = 1; k = 0; spi_cs = 1'b0; word = slave_word[gidx(grant)]; spi_data_out = 8'h11;
      end else if (busy) begin
        k++;
        if (!hang && k == LEN) begin
          spi_cs = 1'b1; busy = 0; spi_data_out = '0;
        end else spi_data_out = (!hang && k == LEN - 1) ? word : W'(8'h11 + k);
      end
    end
  end
  // reference model: a transaction is grant -> one kick cycle -> wait on cs/timeout -> one completion cycle
  logic [N-1:0] m_grant;
  logic m_done, m_err, m_en, m_abort;
  logic [W-1:0] m_rsp, m_din, m_rx;
  int m_ptr, m_idx, m_age;
  bit m_busy, m_fin, m_seen;
  always @(posedge clk) begin
    if (reset) begin
      m_grant = '0; m_done = 0; m_err = 0; m_en = 0; m_abort = 0; m_rsp = '0; m_din = '0;
      m_rx = '0; m_ptr = 0; m_idx = 0; m_age = 0; m_busy = 0; m_fin = 0; m_seen = 0;
    end else begin
      m_done = 0; m_err = 0; m_abort = 0; m_en = 0;
      if (m_fin) begin
        m_fin = 0; m_grant = '0; m_ptr = (m_idx + 1) % N;
      end else if (m_busy) begin
        if (m_age == 0) m_en = 1;
        else begin
          if (!spi_cs) begin m_rx = spi_data_out; m_seen = 1; end
          if (spi_cs && m_seen) begin
            m_busy = 0; m_fin = 1; m_done = 1; m_rsp = m_rx;
          end else if (m_age == TO) begin
            m_busy = 0; m_fin = 1; m_done = 1; m_err = 1; m_abort = 1; m_rsp = '0;
          end
        end
        m_age++;
      end else if (|req) begin
        for (int j = N - 1; j >= 0; j--) if (req[(m_ptr + j) % N]) m_idx = (m_ptr + j) % N;
        m_grant = N'(1) << m_idx; m_din = req_data[m_idx*W +: W];
        m_busy = 1; m_age = 0; m_seen = 0;
      end
    end
  end
  // every-cycle comparison of all outputs against the model
  always @(negedge clk) if (chk_on) begin
    logic [N-1:0] e_ss;
    e_ss = m_busy ? (~m_grant | {N{spi_cs}}) : '1;
    checks++;
    if ({grant, done, err, rsp_data, spi_enable, spi_data_in, spi_abort, ss_n} !==
        {m_grant, m_done, m_err, m_rsp, m_en, m_din, m_abort, e_ss}) begin
      errors++;
      $display("FAIL model t=%0t grant=%b/%b done=%b/%b err=%b/%b rsp=%h/%h en=%b/%b din=%h/%h abort=%b/%b ss_n=%b/%b",
        $time, grant, m_grant, done, m_done, err, m_err, rsp_data, m_rsp, spi_enable, m_en,
        spi_data_in, m_din, spi_abort, m_abort, ss_n, e_ss);
    end
  end
  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (done !== 1'b1 && cyc < 200);
    if (done !== 1'b1) begin
      checks++; errors++;
      $display("FAIL wait_done: got no done expected done within 200 cycles");
    end
  endtask
  task automatic wait_en();
    int cyc;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (spi_enable !== 1'b1 && cyc < 50);
    if (spi_enable !== 1'b1) begin
      checks++; errors++;
      $display("FAIL wait_en: got no spi_enable expected one within 50 cycles");
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100us");
    $fatal(1);
  end
  initial begin
    int c;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    check("rst_grant", 32'(grant), 0);
    check("rst_ss_n", 32'(ss_n), 32'hF);
    check("rst_en_done_abort", {29'd0, spi_enable, done, spi_abort}, 0);
    reset = 1'b0;
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'hF;
    for (int i = 0; i < 5; i++) begin
      wait_done(c);
      if (i == 4) req = '0;
      check($sformatf("rr_grant%0d", i), 32'(grant), 32'(1) << (i % 4));
      check($sformatf("rr_rsp%0d", i), 32'(rsp_data), 32'(slave_word[i % 4]));
      check($sformatf("rr_err%0d", i), 32'(err), 0);
    end
    req = 4'b1000;
    wait_done(c);
    req = '0;
    check("wrap_serve3", 32'(grant), 32'h8);
    @(negedge clk);
    req = 4'b1001;
    wait_done(c);
    check("wrap_first0", 32'(grant), 32'h1);
    wait_done(c);
    req = '0;
    check("wrap_then3", 32'(grant), 32'h8);
    repeat (2) @(negedge clk);
    req_data = {8'h44, 8'h33, 8'h22, 8'hA5};
    req = 4'b0001;
    @(negedge clk);
    check("single_grant", 32'(grant), 32'h1);
    check("single_en_late", 32'(spi_enable), 0);
    req = '0;
    @(negedge clk);
    check("single_en", 32'(spi_enable), 1);
    check("single_din", 32'(spi_data_in), 32'hA5);
    wait_done(c);
    check("single_rsp", 32'(rsp_data), 32'h3C);
    check("single_err", 32'(err), 0);
    @(negedge clk);
    check("single_grant_clr", 32'(grant), 0);
    hang = 1'b1;
    req = 4'b0100;
    wait_en();
    req = '0;
    wait_done(c);
    check("to_cycles", c, 16);
    check("to_err_abort", {30'd0, err, spi_abort}, 3);
    check("to_rsp", 32'(rsp_data), 0);
    check("to_grant", 32'(grant), 32'h4);
    hang = 1'b0;
    @(negedge clk);
    check("to_idle", 32'(grant), 0);
    req = 4'b0010;
    wait_en();
    req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rstmid_grant", 32'(grant), 0);
    check("rstmid_ss_n", 32'(ss_n), 32'hF);
    check("rstmid_en_done", {30'd0, spi_enable, done}, 0);
    reset = 1'b0;
    req = 4'b1001;
    @(negedge clk);
    check("rstmid_ptr0", 32'(grant), 32'h1);
    req = '0;
    wait_done(c);
    check("rstmid_rsp", 32'(rsp_data), 32'h3C);
    repeat (2) @(negedge clk);
    req_data = {8'h77, 8'h33, 8'h22, 8'h11};
    req = 4'b1000;
    wait_en();
    repeat (2) @(negedge clk);
    req_data = '1;
    req = '0;
    @(negedge clk);
    check("stab_din_mid", 32'(spi_data_in), 32'h77);
    wait_done(c);
    check("stab_din_end", 32'(spi_data_in), 32'h77);
    check("stab_grant", 32'(grant), 32'h8);
    check("stab_rsp", 32'(rsp_data), 32'(slave_word[3]));
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
